// File: rtl/vga_sync_receiver_if.sv
`default_nettype none
// ============================================================================
// Module  : vga_sync_receiver_if
// Brief   : Sync inputs and recovered-timing outputs of vga_sync_receiver.
// Rev     : 1.0
// ============================================================================
interface vga_sync_receiver_if;
  logic       i_hSync;
  logic       i_vSync;
  logic [9:0] o_hCnt;
  logic [9:0] o_vCnt;
  logic       o_de;
  logic       o_frameStart;
  logic       o_locked;
  logic       o_lockLost;

  modport master (
    output i_hSync, i_vSync,
    input  o_hCnt, o_vCnt, o_de, o_frameStart, o_locked, o_lockLost
  );

  modport slave (
    input  i_hSync, i_vSync,
    output o_hCnt, o_vCnt, o_de, o_frameStart, o_locked, o_lockLost
  );
endinterface
`default_nettype wire

// File: rtl/vga_sync_receiver.sv
`default_nettype none
// ============================================================================
// Module  : vga_sync_receiver
// Brief   : Recovers pixel position and display enable from VGA hsync/vsync.
// Rev     : 1.0
// ============================================================================
module vga_sync_receiver #(
  parameter int HBP         = 48,
  parameter int HACTIVE     = 640,
  parameter int HFP         = 16,
  parameter int HSYN        = 96,
  parameter int VBP         = 32,
  parameter int VACTIVE     = 480,
  parameter int VFP         = 11,
  parameter int VSYN        = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic               i_clk,
  input  logic               i_arst,
  vga_sync_receiver_if.slave vga
);

  localparam int         c_htotal       = HBP + HACTIVE + HFP + HSYN;
  localparam int         c_vtotal       = VBP + VACTIVE + VFP + VSYN;
  localparam logic [9:0] c_h_last       = 10'(c_htotal - 1);
  localparam logic [9:0] c_v_last       = 10'(c_vtotal - 1);
  localparam logic [9:0] c_h_sync_start = 10'(HACTIVE + HFP);
  localparam logic [9:0] c_v_sync_start = 10'(VACTIVE + VFP);
  localparam logic [9:0] c_sat          = 10'd1023;
  localparam logic [10:0] c_timeout     = 11'(2 * c_htotal);

  localparam logic [1:0] c_st_search  = 2'd0;
  localparam logic [1:0] c_st_acquire = 2'd1;
  localparam logic [1:0] c_st_locked  = 2'd2;

  logic        r_h_prev;
  logic        r_v_prev;
  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic [9:0]  r_h_width;
  logic [9:0]  r_v_width;
  logic [9:0]  r_frame_lines;
  logic [10:0] r_line_timer;
  logic        r_frame_bad;
  logic [3:0]  r_good_cnt;
  logic [1:0]  r_state;
  logic        r_frame_start;
  logic        r_lock_lost;

  logic        w_h_fall;
  logic        w_h_rise;
  logic        w_v_fall;
  logic        w_h_wrap;
  logic        w_line_bad;
  logic        w_timeout;
  logic        w_frame_good;
  logic        w_origin;
  logic [3:0]  w_good_inc;
  logic [1:0]  w_state_nxt;
  logic [3:0]  w_good_nxt;
  logic        w_lost;

  assign w_h_fall     = r_h_prev & ~vga.i_hSync;
  assign w_h_rise     = ~r_h_prev & vga.i_hSync;
  assign w_v_fall     = r_v_prev & ~vga.i_vSync;
  // An hsync reload takes precedence, so a late line never produces a wrap.
  assign w_h_wrap     = ~w_h_fall & (r_h_cnt == c_h_last);
  assign w_line_bad   = w_h_rise & (r_h_width != 10'(HSYN));
  assign w_timeout    = (r_line_timer >= c_timeout);
  assign w_frame_good = ~r_frame_bad & (r_v_width == 10'(VSYN))
                      & (r_frame_lines == 10'(c_vtotal));
  assign w_origin     = w_h_wrap & ~w_v_fall & (r_v_cnt == c_v_last);
  assign w_good_inc   = r_good_cnt + 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_lost      = 1'b0;
    case (r_state)
      c_st_search: begin
        if (w_v_fall) begin
          w_state_nxt = c_st_acquire;
          w_good_nxt  = 4'd0;
        end
      end
      c_st_acquire: begin
        if (w_timeout) begin
          w_state_nxt = c_st_search;
        end else if (w_v_fall) begin
          if (!w_frame_good) begin
            w_good_nxt = 4'd0;
          end else begin
            w_good_nxt = w_good_inc;
            if (w_good_inc >= 4'(LOCK_FRAMES)) begin
              w_state_nxt = c_st_locked;
            end
          end
        end
      end
      c_st_locked: begin
        if (w_timeout || w_line_bad || (w_v_fall && !w_frame_good)) begin
          w_state_nxt = c_st_search;
          w_lost      = 1'b1;
        end
      end
      default: w_state_nxt = c_st_search;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_h_prev <= 1'b1;
      r_v_prev <= 1'b1;
      r_h_cnt  <= 10'd0;
      r_v_cnt  <= 10'd0;
    end else begin
      r_h_prev <= vga.i_hSync;
      r_v_prev <= vga.i_vSync;
      if (w_h_fall) begin
        r_h_cnt <= c_h_sync_start;
      end else if (w_h_wrap) begin
        r_h_cnt <= 10'd0;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
      if (w_v_fall) begin
        r_v_cnt <= c_v_sync_start;
      end else if (w_h_wrap) begin
        r_v_cnt <= (r_v_cnt == c_v_last) ? 10'd0 : r_v_cnt + 10'd1;
      end
    end
  end

  // Measurements restart at the vsync edge but still count that clock's wrap,
  // so the frame being closed only sees activity strictly before the edge.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_h_width     <= 10'd0;
      r_v_width     <= 10'd0;
      r_frame_lines <= 10'd0;
      r_line_timer  <= 11'd0;
      r_frame_bad   <= 1'b0;
    end else begin
      if (w_h_fall) begin
        r_h_width <= 10'd1;
      end else if (!vga.i_hSync && r_h_width != c_sat) begin
        r_h_width <= r_h_width + 10'd1;
      end

      if (w_h_fall) begin
        r_line_timer <= 11'd0;
      end else if (!w_timeout) begin
        r_line_timer <= r_line_timer + 11'd1;
      end

      if (w_v_fall) begin
        r_v_width     <= w_h_wrap ? 10'd1 : 10'd0;
        r_frame_lines <= w_h_wrap ? 10'd1 : 10'd0;
        r_frame_bad   <= w_line_bad | w_timeout;
      end else begin
        if (w_h_wrap && !vga.i_vSync && r_v_width != c_sat) begin
          r_v_width <= r_v_width + 10'd1;
        end
        if (w_h_wrap && r_frame_lines != c_sat) begin
          r_frame_lines <= r_frame_lines + 10'd1;
        end
        if (w_line_bad || w_timeout) begin
          r_frame_bad <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_state       <= c_st_search;
      r_good_cnt    <= 4'd0;
      r_frame_start <= 1'b0;
      r_lock_lost   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_good_cnt    <= w_good_nxt;
      r_frame_start <= w_origin & (w_state_nxt == c_st_locked);
      r_lock_lost   <= w_lost;
    end
  end

  assign vga.o_hCnt       = r_h_cnt;
  assign vga.o_vCnt       = r_v_cnt;
  assign vga.o_locked     = (r_state == c_st_locked);
  assign vga.o_de         = vga.o_locked && (r_h_cnt < 10'(HACTIVE))
                          && (r_v_cnt < 10'(VACTIVE));
  assign vga.o_frameStart = r_frame_start;
  assign vga.o_lockLost   = r_lock_lost;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_receiver.sv
`default_nettype none
// tb_vga_sync_receiver: scaled-timing sync stream with random phase and faults,
// compared every clock against a position/event reference model.
module tb_vga_sync_receiver;

  localparam int HBP = 4, HACTIVE = 16, HFP = 3, HSYN = 5;
  localparam int VBP = 3, VACTIVE = 10, VFP = 2, VSYN = 2;
  localparam int LOCK_FRAMES = 2;
  localparam int HT = HBP + HACTIVE + HFP + HSYN;
  localparam int VT = VBP + VACTIVE + VFP + VSYN;
  localparam int M_SEARCH = 0, M_ACQUIRE = 1, M_LOCKED = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_sync_receiver_if vif();

  vga_sync_receiver #(
    .HBP(HBP), .HACTIVE(HACTIVE), .HFP(HFP), .HSYN(HSYN),
    .VBP(VBP), .VACTIVE(VACTIVE), .VFP(VFP), .VSYN(VSYN),
    .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .i_clk (clk),
    .i_arst(rst),
    .vga   (vif)
  );

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       de;
    logic       fs;
    logic       lk;
    logic       ll;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: position is derived from time since the last sync edges.
  int m_n, m_t_hfall, m_wraps_total, m_wraps_after_v, m_lines, m_vlow, m_good, m_mode;
  bit m_hseen, m_vseen, m_flaw, m_hprev, m_vprev;

  task automatic model_reset();
    m_n = 0; m_t_hfall = 0; m_wraps_total = 0; m_wraps_after_v = 0;
    m_lines = 0; m_vlow = 0; m_good = 0; m_mode = M_SEARCH;
    m_hseen = 0; m_vseen = 0; m_flaw = 0; m_hprev = 1; m_vprev = 1;
  endtask

  task automatic model_step(input bit hs, input bit vs);
    bit   hf, hr, vf, tmo, lbad, wrap, fg, lost, lk;
    int   h, v;
    exp_t e;
    m_n++;
    hf   = m_hprev && !hs;
    hr   = !m_hprev && hs;
    vf   = m_vprev && !vs;
    tmo  = (m_n - 1 - m_t_hfall) >= 2 * HT;
    lbad = hr && ((m_n - m_t_hfall) != HSYN);
    if (hf) begin
      m_hseen   = 1;
      m_t_hfall = m_n;
    end
    h    = m_hseen ? (HACTIVE + HFP + m_n - m_t_hfall) % HT : m_n % HT;
    wrap = (h == 0);
    if (wrap) m_wraps_total++;
    fg = !m_flaw && (m_vlow == VSYN) && (m_lines == VT);
    if (vf) begin
      m_vseen = 1;
      m_wraps_after_v = 0;
      m_lines = wrap ? 1 : 0;
      m_vlow  = wrap ? 1 : 0;
      m_flaw  = lbad || tmo;
    end else begin
      if (wrap) begin
        m_wraps_after_v++;
        m_lines++;
        if (!vs) m_vlow++;
      end
      if (lbad || tmo) m_flaw = 1;
    end
    v = m_vseen ? (VACTIVE + VFP + m_wraps_after_v) % VT : m_wraps_total % VT;
    lost = 0;
    case (m_mode)
      M_SEARCH: if (vf) begin m_mode = M_ACQUIRE; m_good = 0; end
      M_ACQUIRE: begin
        if (tmo) m_mode = M_SEARCH;
        else if (vf) begin
          if (fg) begin
            m_good++;
            if (m_good >= LOCK_FRAMES) m_mode = M_LOCKED;
          end else m_good = 0;
        end
      end
      default: if (tmo || lbad || (vf && !fg)) begin m_mode = M_SEARCH; lost = 1; end
    endcase
    lk   = (m_mode == M_LOCKED);
    e.h  = 10'(h);
    e.v  = 10'(v);
    e.lk = lk;
    e.de = lk && (h < HACTIVE) && (v < VACTIVE);
    e.fs = wrap && (v == 0) && lk;
    e.ll = lost;
    exp_q.push_back(e);
    m_hprev = hs;
    m_vprev = vs;
  endtask

  // Stream source with per-line fault knobs.
  int src_h, src_v;
  int cur_len = HT, cur_hw = HSYN, cur_vsw = VSYN;
  bit cur_force = 0;
  int line_len = HT, bad_arm = 0, bad_w = HSYN - 1, force_lines = 0, vsw3_arm = 0;

  task automatic tick();
    bit   hs, vs;
    exp_t z;
    if (src_h == 0) begin
      cur_len = line_len; cur_hw = HSYN; cur_force = 0;
      if (bad_arm != 0) begin cur_hw = bad_w; bad_arm = 0; end
      if (force_lines > 0) begin cur_force = 1; force_lines--; end
      if (src_v == 0) begin cur_vsw = (vsw3_arm != 0) ? 3 : VSYN; vsw3_arm = 0; end
    end
    hs = !(!cur_force && src_h >= HACTIVE + HFP && src_h < HACTIVE + HFP + cur_hw);
    vs = !(src_v >= VACTIVE + VFP && src_v < VACTIVE + VFP + cur_vsw);
    vif.i_hSync = hs;
    vif.i_vSync = vs;
    if (rst) begin
      model_reset();
      z = '0;
      exp_q.push_back(z);
    end else begin
      model_step(hs, vs);
    end
    @(posedge clk);
    #1;
    if (src_h >= cur_len - 1) begin
      src_h = 0;
      src_v = (src_v + 1) % VT;
    end else begin
      src_h++;
    end
  endtask

  task automatic run_lines(input int n);
    repeat (n) begin
      tick();
      while (src_h != 0) tick();
    end
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if ({vif.o_hCnt, vif.o_vCnt, vif.o_de, vif.o_frameStart, vif.o_locked, vif.o_lockLost} !== 24'd0) begin
      miscompares++;
      $display("FAIL async_reset got h=%0d v=%0d de=%0b fs=%0b lk=%0b ll=%0b expected all zero",
               vif.o_hCnt, vif.o_vCnt, vif.o_de, vif.o_frameStart, vif.o_locked, vif.o_lockLost);
    end
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Monitor: pops one expected vector per clock and checks per-frame DE totals.
  exp_t mon_e, mon_a;
  int   de_cnt = 0;
  bit   win_ok = 0;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {vif.o_hCnt, vif.o_vCnt, vif.o_de, vif.o_frameStart, vif.o_locked, vif.o_lockLost};
      vectors++;
      if (mon_a !== mon_e) begin
        miscompares++;
        $display("FAIL cycle t=%0t got h=%0d v=%0d de=%0b fs=%0b lk=%0b ll=%0b expected h=%0d v=%0d de=%0b fs=%0b lk=%0b ll=%0b",
                 $time, mon_a.h, mon_a.v, mon_a.de, mon_a.fs, mon_a.lk, mon_a.ll,
                 mon_e.h, mon_e.v, mon_e.de, mon_e.fs, mon_e.lk, mon_e.ll);
      end
      if (!vif.o_locked) win_ok = 0;
      if (vif.o_frameStart) begin
        if (win_ok) begin
          vectors++;
          if (de_cnt != HACTIVE * VACTIVE) begin
            miscompares++;
            $display("FAIL de_per_frame got %0d expected %0d", de_cnt, HACTIVE * VACTIVE);
          end
        end
        win_ok = vif.o_locked;
        de_cnt = 0;
      end
      if (vif.o_de) de_cnt++;
    end
  end

  initial begin
    vif.i_hSync = 1'b1;
    vif.i_vSync = 1'b1;
    src_v = $urandom_range(0, VT - 1);
    src_h = $urandom_range(0, HT - 1);
    #2 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    run_lines(5 * VT);                       // nominal stream from reset

    line_len = HT + 1;                       // one extra clock per line
    run_lines(4 * VT);
    line_len = HT;

    run_lines($urandom_range(0, VT - 1));    // one narrow hsync pulse
    bad_arm = 1;
    run_lines(5 * VT);

    run_lines($urandom_range(0, VT - 1));    // hsync stuck high for 3 lines
    force_lines = 3;
    run_lines(5 * VT);

    run_lines($urandom_range(1, VT - 1));    // reset mid-line while locked
    repeat ($urandom_range(1, HT - 2)) tick();
    async_reset_check();

    vsw3_arm = 1;                            // 3-line vsync while acquiring
    run_lines(6 * VT);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
